// File: rtl/countdown_timer_ctrl_if.sv
// Button and display bundle for the MM:SS countdown timer controller.
// The master side drives the debounced button levels; the slave side drives the display fields.
interface countdown_timer_ctrl_if;
  logic       btn_mode_i;
  logic       btn_inc_i;
  logic       btn_start_i;
  logic [7:0] min_o;
  logic [7:0] sec_o;
  logic [1:0] flick_o;
  logic       running_o;
  logic       done_o;

  modport master (
    output btn_mode_i, btn_inc_i, btn_start_i,
    input  min_o, sec_o, flick_o, running_o, done_o
  );

  modport slave (
    input  btn_mode_i, btn_inc_i, btn_start_i,
    output min_o, sec_o, flick_o, running_o, done_o
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Mode/sequence controller for the MM:SS countdown timer: button edge detection,
// set/run/pause/done sequencing and the BCD minute/second registers.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  countdown_timer_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_MIN,
    S_SET_SEC,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  // BCD +1 within 00..59, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD -1 for a nonzero value: units 0 borrows from tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] != 4'd0) r = {v[7:4], v[3:0] - 4'd1};
    else                r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  // One-second decrement of {min, sec}; 00:00 saturates.
  function automatic logic [15:0] time_dec(input logic [7:0] m_v, input logic [7:0] s_v);
    logic [15:0] r;
    if (s_v != 8'h00)      r = {m_v, bcd_dec(s_v)};
    else if (m_v != 8'h00) r = {bcd_dec(m_v), 8'h59};
    else                   r = 16'h0000;
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       sec_q, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       btn_hist_q, btn_hist_d;   // {start, mode, inc}
  logic [1:0]       flick_q, flick_d;
  logic             running_q, running_d;
  logic             done_q, done_d;

  logic [2:0]       btn_lvl;
  logic [2:0]       press;
  logic             start_p, mode_p, inc_p;
  logic             nonzero;
  logic             tick;
  logic [15:0]      dec_time;
  logic             dec_zero;

  assign btn_lvl  = {bus.btn_start_i, bus.btn_mode_i, bus.btn_inc_i};
  assign press    = btn_lvl & ~btn_hist_q;
  assign start_p  = press[2];
  assign mode_p   = press[1] & ~press[2];
  assign inc_p    = press[0] & ~press[1] & ~press[2];
  assign nonzero  = {min_q, sec_q} != 16'h0000;
  assign tick     = cnt_q == TICK_LAST;
  assign dec_time = time_dec(min_q, sec_q);
  assign dec_zero = dec_time == 16'h0000;

  // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    cnt_d      = cnt_q;
    btn_hist_d = btn_lvl;

    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          if (nonzero) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end else if (mode_p) begin
          state_d = S_SET_MIN;
        end
      end

      S_SET_MIN: begin
        if (start_p) begin
          state_d = nonzero ? S_RUN : S_IDLE;
          cnt_d   = '0;
        end else if (mode_p) begin
          state_d = S_SET_SEC;
        end else if (inc_p) begin
          min_d = bcd_inc59(min_q);
        end
      end

      S_SET_SEC: begin
        if (start_p) begin
          state_d = nonzero ? S_RUN : S_IDLE;
          cnt_d   = '0;
        end else if (mode_p) begin
          state_d = S_IDLE;
        end else if (inc_p) begin
          sec_d = bcd_inc59(sec_q);
        end
      end

      S_RUN: begin
        // The counter keeps stepping on the edge that pauses, so a tick there still lands.
        if (tick) begin
          {min_d, sec_d} = dec_time;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (tick && dec_zero) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (start_p) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (start_p) begin
          state_d = S_RUN;
        end else if (mode_p) begin
          state_d = S_SET_MIN;
          cnt_d   = '0;
        end
      end

      S_DONE: begin
        if (start_p || mode_p) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    flick_d   = 2'b00;
    running_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_d)
      S_SET_MIN: flick_d = 2'b10;
      S_SET_SEC: flick_d = 2'b01;
      S_PAUSE:   flick_d = 2'b11;
      S_DONE: begin
        flick_d = 2'b11;
        done_d  = 1'b1;
      end
      S_RUN:     running_d = 1'b1;
      default:   flick_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      cnt_q      <= '0;
      btn_hist_q <= 3'b000;
      flick_q    <= 2'b00;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      btn_hist_q <= btn_hist_d;
      flick_q    <= flick_d;
      running_q  <= running_d;
      done_q     <= done_d;
    end
  end

  assign bus.min_o     = min_q;
  assign bus.sec_o     = sec_q;
  assign bus.flick_o   = flick_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: a seconds-based reference model predicts each
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_countdown_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  countdown_timer_ctrl_if tm_if ();

  countdown_timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tm_if)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_SET_MIN, M_SET_SEC, M_RUN, M_PAUSE, M_DONE} mstate_e;

  typedef struct {
    int unsigned cyc;
    logic [20:0] val;
    string       name;
  } exp_t;

  mstate_e     m_state;
  int          m_min, m_sec, m_cnt;
  logic [2:0]  m_hist;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_print = 0;
  string       phase = "reset";
  logic [20:0] dut_out;

  assign dut_out = {tm_if.min_o, tm_if.sec_o, tm_if.flick_o, tm_if.running_o, tm_if.done_o};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input logic [20:0] v);
    return $sformatf("%h:%h flick=%b run=%b done=%b", v[20:13], v[12:5], v[4:3], v[2], v[1]);
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      if (n_print < 30) $display("FAIL %s @cyc %0d: got %s, expected %s", name, cyc, fmt(act), fmt(exp));
      n_print++;
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [20:0] model_out();
    logic [1:0] f;
    case (m_state)
      M_SET_MIN:      f = 2'b10;
      M_SET_SEC:      f = 2'b01;
      M_PAUSE, M_DONE: f = 2'b11;
      default:        f = 2'b00;
    endcase
    return {to_bcd(m_min), to_bcd(m_sec), f, m_state == M_RUN, m_state == M_DONE};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_min   = 0;
    m_sec   = 0;
    m_cnt   = 0;
    m_hist  = 3'b000;
  endtask

  // Reference behaviour, with the remaining time kept as a plain count of seconds.
  task automatic model_step(input logic r, input logic m, input logic i, input logic s);
    logic [2:0] lvl, pr;
    logic       ps, pm, pi;
    int         total;
    if (r) begin
      model_reset();
    end else begin
      lvl    = {s, m, i};
      pr     = lvl & ~m_hist;
      m_hist = lvl;
      ps     = pr[2];
      pm     = pr[1];
      pi     = pr[0];
      total  = m_min * 60 + m_sec;
      case (m_state)
        M_IDLE: begin
          if (ps) begin
            if (total != 0) begin m_state = M_RUN; m_cnt = 0; end
          end else if (pm) m_state = M_SET_MIN;
        end
        M_SET_MIN: begin
          if (ps) begin m_state = (total != 0) ? M_RUN : M_IDLE; m_cnt = 0; end
          else if (pm) m_state = M_SET_SEC;
          else if (pi) m_min = (m_min + 1) % 60;
        end
        M_SET_SEC: begin
          if (ps) begin m_state = (total != 0) ? M_RUN : M_IDLE; m_cnt = 0; end
          else if (pm) m_state = M_IDLE;
          else if (pi) m_sec = (m_sec + 1) % 60;
        end
        M_RUN: begin
          m_cnt++;
          if (m_cnt == TICK_DIV) begin
            m_cnt = 0;
            total = total - 1;
            m_min = total / 60;
            m_sec = total % 60;
            if (total == 0) m_state = M_DONE;
          end
          if (m_state == M_RUN && ps) m_state = M_PAUSE;
        end
        M_PAUSE: begin
          if (ps) m_state = M_RUN;
          else if (pm) begin m_state = M_SET_MIN; m_cnt = 0; end
        end
        M_DONE: begin
          if (ps || pm) m_state = M_IDLE;
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  // One clock of stimulus: apply levels after the edge, predict the next edge's outputs.
  task automatic drive(input logic r, input logic m, input logic i, input logic s);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    tm_if.btn_mode_i  = m;
    tm_if.btn_inc_i   = i;
    tm_if.btn_start_i = s;
    model_step(r, m, i, s);
    e.cyc  = cyc + 1;
    e.val  = model_out();
    e.name = phase;
    sb_q.push_back(e);
  endtask

  task automatic press(input logic m, input logic i, input logic s);
    drive(1'b0, m, i, s);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges, after the monitor has sampled this cycle.
  task automatic async_reset(input int hold);
    @(posedge clk);
    #4;
    rst               = 1'b1;
    tm_if.btn_mode_i  = 1'b0;
    tm_if.btn_inc_i   = 1'b0;
    tm_if.btn_start_i = 1'b0;
    model_reset();
    #1;
    check("rst_async", dut_out, model_out());
    repeat (hold) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every prediction due at this cycle, independently of the driver.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        if (e.cyc != cyc) begin
          n_checks++;
          $display("FAIL stale_%s: prediction for cyc %0d unchecked at cyc %0d", e.name, e.cyc, cyc);
        end else begin
          check(e.name, dut_out, e.val);
        end
      end
    end
  end

  initial begin
    logic [2:0] lvl;
    tm_if.btn_mode_i  = 1'b0;
    tm_if.btn_inc_i   = 1'b0;
    tm_if.btn_start_i = 1'b0;
    model_reset();

    phase = "reset";
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);

    phase = "set_values";
    press(1, 0, 0);
    repeat (2) press(0, 1, 0);
    repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    press(1, 0, 0);
    repeat (61) press(0, 1, 0);
    press(1, 0, 0);

    phase = "run_to_done";
    async_reset(2);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    idle(250);
    press(0, 0, 1);

    phase = "pause_resume";
    press(1, 0, 0);
    repeat (2) press(0, 1, 0);
    press(1, 0, 0);
    repeat (10) press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    idle(5);
    press(0, 0, 1);
    idle(20);
    press(0, 0, 1);
    idle(12);
    press(0, 0, 1);
    press(1, 0, 0);
    idle(3);

    phase = "rst_mid_run";
    press(1, 0, 0);
    press(0, 0, 1);
    idle(7);
    async_reset(3);
    idle(3);

    phase = "zero_start";
    press(0, 0, 1);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    idle(2);

    phase = "start_inc_same";
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 1);
    idle(8);
    press(1, 0, 0);

    phase = "tick_and_start";
    async_reset(1);
    press(1, 0, 0);
    press(1, 0, 0);
    repeat (2) press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    press(0, 0, 1);
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    phase = "random";
    async_reset(1);
    lvl = 3'b000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset(1);
        lvl = 3'b000;
      end else begin
        if ($urandom_range(0, 3) == 0)  lvl[0] = ~lvl[0];
        if ($urandom_range(0, 9) == 0)  lvl[1] = ~lvl[1];
        if ($urandom_range(0, 19) == 0) lvl[2] = ~lvl[2];
        drive(1'b0, lvl[1], lvl[0], lvl[2]);
      end
    end

    phase = "drain";
    idle(3);
    repeat (2) @(posedge clk);
    #5;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Mode/sequence controller for the MM:SS countdown timer.
- Turns three button levels into set/run/pause/done behaviour and owns the BCD minute/second registers.
- Drives the four-digit display driver directly: min_o/sec_o feed its min/sec inputs, flick_o feeds its blink-select input (bit1 = minute digits, bit0 = second digits).

Parameters:
- TICK_DIV, 100000000: clk cycles per one-second countdown tick. Must be ≥2.
- CNT_W, 27: tick counter width. Must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- btn_mode_i, input, 1: mode button level. Already synchronized and debounced.
- btn_inc_i, input, 1: increment button level. Already synchronized and debounced.
- btn_start_i, input, 1: start/pause button level. Already synchronized and debounced.
- min_o, output, 8: minutes in BCD, {tens, units}.
- sec_o, output, 8: seconds in BCD, {tens, units}.
- flick_o, output, 2: blink select. 10 = minutes, 01 = seconds, 11 = all, 00 = none.
- running_o, output, 1: high while in state RUN.
- done_o, output, 1: high while in state DONE.

Behaviour:

Reset:
- While rst=1: state IDLE, min_o=00, sec_o=00, flick_o=00, running_o=0, done_o=0, tick counter 0, button history registers 0.

Edge detection:
- Each button has a history register; press = level & ~history.
- An action commits on the same rising edge where the level is first sampled high.
- Holding a button produces exactly one press.
- Priority when several presses occur in one cycle: start > mode > inc. Lower-priority presses in that cycle are discarded.

"Nonzero" below means {min_o, sec_o} != 16'h0000.

States and transitions:
- IDLE (flick 00):
  - mode → SET_MIN.
  - start → RUN if nonzero, else stay IDLE.
  - inc ignored.
- SET_MIN (flick 10):
  - inc: min +1 BCD, 59 wraps to 00.
  - mode → SET_SEC.
  - start → RUN if nonzero, else IDLE.
- SET_SEC (flick 01):
  - inc: sec +1 BCD, 59 wraps to 00, no carry into min.
  - mode → IDLE.
  - start → RUN if nonzero, else IDLE.
- RUN (flick 00, running_o=1):
  - Tick counter increments each cycle.
  - When the counter equals TICK_DIV-1: counter returns to 0 and one decrement is applied.
  - Decrement: sec units-1; units 0 borrows from tens (x0 → (x-1)9). Sec 00 with min>0 → sec 59, min -1 BCD.
  - If the result is 00:00 → DONE.
  - start → PAUSE, tick counter held.
  - mode and inc ignored.
- PAUSE (flick 11):
  - start → RUN, tick counter resumes from its held value.
  - mode → SET_MIN, tick counter cleared.
  - inc ignored.
- DONE (flick 11, done_o=1):
  - start or mode → IDLE; time stays 00:00.
  - inc ignored.

Tick counter rules:
- Cleared on every entry to RUN except PAUSE→RUN.
- Cleared on every exit to a non-PAUSE state.

Output timing:
- All outputs are registered.
- running_o, done_o and flick_o reflect the new state on the edge that commits the transition.

Boundary cases:
- Tick and start in the same RUN cycle: the decrement is applied and the state goes to PAUSE. If that decrement reaches 00:00, the state goes to DONE instead.
- Time 00:01 in RUN: the next tick gives 00:00 and DONE in the same edge.
- BCD invariants: units nibble is always 0–9; tens nibble is always 0–5. No illegal codes are ever produced.
- rst asserted mid-RUN: immediate return to the reset values above.

Test Plan (TICK_DIV=4):
- Reset then idle 10 cycles → min_o=00, sec_o=00, flick_o=00, running_o=0, done_o=0.
- mode; inc ×3; mode; inc ×61 → after first mode flick_o=10; min_o=03; after second mode flick_o=01; sec_o=01 (wrapped 59→00 then +1). Holding inc 5 cycles counts as one press.
- From 01:00, start → running_o=1; after 4 cycles 00:59; after 240 cycles total done_o=1, flick_o=11, time 00:00.
- In RUN at 02:10: start → PAUSE, flick_o=11, value frozen 20 cycles; start again → decrement occurs exactly (4 - cycles already counted) cycles later.
- Start with time 00:00 in IDLE and in SET_SEC → state stays or returns to IDLE, running_o stays 0.
- start and inc pressed in the same cycle in SET_MIN → RUN entered, min unchanged. Tick coinciding with start → decrement applied and PAUSE entered. rst during RUN → all outputs return to zero immediately.
